// File: rtl/wb_stage.sv
// Write-back stage: registers ALU/link results and runs the req/ack
// data-memory read for loads before pulsing the register-file write.
module wb_stage #(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [5:0]  in_op,
    input  logic [5:0]  in_func,
    input  logic [4:0]  in_write_reg,
    input  logic [31:0] in_alu_result,
    input  logic [31:0] in_npc,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        reg_write,
    output logic [4:0]  write_reg,
    output logic [31:0] write_data,
    output logic        err
);

    localparam logic [0:0] IDLE     = 1'b0;
    localparam logic [0:0] MEM_WAIT = 1'b1;

    logic [0:0]  state;
    logic [15:0] cnt;
    logic        ld_byte;
    logic [1:0]  ld_off;
    logic [4:0]  ld_dst;

    logic        accept;
    logic        is_alu;
    logic        is_jal;
    logic        is_lw;
    logic        is_lb;
    logic        timeout_hit;
    logic [7:0]  sel_byte;
    logic [31:0] ld_value;

    assign in_ready = (state == IDLE);
    assign accept   = in_valid && in_ready;

    always_comb begin
        is_alu = 1'b0;
        is_jal = 1'b0;
        is_lw  = 1'b0;
        is_lb  = 1'b0;
        unique case (in_op)
            6'b000000: is_alu = (in_func != 6'b001000);
            6'b001000,
            6'b001001,
            6'b001100,
            6'b001101,
            6'b001110,
            6'b001111: is_alu = 1'b1;
            6'b000011: is_jal = 1'b1;
            6'b100011: is_lw  = 1'b1;
            6'b100000: is_lb  = 1'b1;
            default: ;
        endcase
    end

    // Little-endian byte lane picked by the latched address offset
    assign sel_byte = mem_rdata[{ld_off, 3'b000} +: 8];
    assign ld_value = ld_byte ? {{24{sel_byte[7]}}, sel_byte} : mem_rdata;

    assign timeout_hit = (TIMEOUT_CYCLES != 16'd0)
                      && ((cnt + 16'd1) == TIMEOUT_CYCLES);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= 16'd0;
            ld_byte    <= 1'b0;
            ld_off     <= 2'b00;
            ld_dst     <= 5'd0;
            mem_req    <= 1'b0;
            mem_addr   <= 32'd0;
            reg_write  <= 1'b0;
            write_reg  <= 5'd0;
            write_data <= 32'd0;
            err        <= 1'b0;
        end else begin
            reg_write <= 1'b0;
            err       <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= 16'd0;
                    if (accept) begin
                        if ((is_alu || is_jal) && in_write_reg != 5'd0) begin
                            reg_write  <= 1'b1;
                            write_reg  <= in_write_reg;
                            write_data <= is_jal ? in_npc : in_alu_result;
                        end else if (is_lw || is_lb) begin
                            state    <= MEM_WAIT;
                            mem_req  <= 1'b1;
                            mem_addr <= {in_alu_result[31:2], 2'b00};
                            ld_byte  <= is_lb;
                            ld_off   <= in_alu_result[1:0];
                            ld_dst   <= in_write_reg;
                        end
                    end
                end
                MEM_WAIT: begin
                    // Ack takes priority over a timeout landing in the same cycle
                    if (mem_ack) begin
                        state   <= IDLE;
                        mem_req <= 1'b0;
                        cnt     <= 16'd0;
                        if (ld_dst != 5'd0) begin
                            reg_write  <= 1'b1;
                            write_reg  <= ld_dst;
                            write_data <= ld_value;
                        end
                    end else if (timeout_hit) begin
                        state   <= IDLE;
                        mem_req <= 1'b0;
                        cnt     <= 16'd0;
                        err     <= 1'b1;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Write-back end of the 5-stage MIPS pipeline. It produces the `reg_write`/`write_reg`/`write_data` triple that the ID stage consumes to update its register file and forward operands.
- Accepts one retired instruction per handshake from the MEM side.
- For loads, performs a req/ack read of data memory, extracts the word or sign-extended byte, then issues a one-cycle register write pulse.
- Stores, branches, J and JR are consumed without a write.

Parameters:
- TIMEOUT_CYCLES, 255, max cycles `mem_req` stays high without `mem_ack` before the load is aborted. 0 disables the timeout. 16-bit range.

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream instruction valid.
- in_ready  output  1  block can accept an instruction this cycle.
- in_op  input  6  opcode, ins[31:26].
- in_func  input  6  function field, ins[5:0].
- in_write_reg  input  5  destination register (rt, rd or 31, already selected upstream).
- in_alu_result  input  32  ALU result; holds the effective address for loads.
- in_npc  input  32  next PC of the instruction (link value for JAL).
- mem_req  output  1  data-memory read request.
- mem_addr  output  32  word-aligned read address.
- mem_ack  input  1  read data valid.
- mem_rdata  input  32  read data.
- reg_write  output  1  register-file write strobe, one-cycle pulse.
- write_reg  output  5  register index.
- write_data  output  32  register write data.
- err  output  1  one-cycle pulse on load timeout.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE.
  - reg_write, write_reg, write_data, mem_req, mem_addr, err = 0.
  - Timeout counter = 0.
  - Any in-flight load is dropped; no write is issued after reset releases.
- in_ready = (state==IDLE). An instruction is accepted on a rising edge with in_valid && in_ready.
- Decode is from in_op/in_func only:
  - ALU writers: op 000000 except func 001000 (JR); ADDI 001000, ADDIU 001001, ANDI 001100, ORI 001101, XORI 001110, LUI 001111.
  - Link: JAL 000011.
  - Loads: LW 100011, LB 100000.
  - Everything else (SW, SB, BEQ, BNE, BGTZ, J, JR, unknown) is no-write.
- ALU writer accepted at edge N:
  - At edge N the outputs are registered: reg_write=1, write_reg=in_write_reg, write_data=in_alu_result.
  - They are visible in cycle N+1. Latency is 1 and the state stays IDLE.
- JAL: same timing, write_reg=in_write_reg, write_data=in_npc.
- No-write instruction: reg_write=0 next cycle; write_reg and write_data hold their previous values.
- reg_write is 1 for exactly one cycle per writing instruction. Back-to-back ALU writers produce consecutive pulses.
- Destination 0: the instruction is accepted but reg_write stays 0.
- Load accepted at edge N:
  - state→MEM_WAIT; mem_req=1 and mem_addr={in_alu_result[31:2],2'b00} from cycle N+1.
  - Effective address bits [1:0] are latched.
  - mem_req and mem_addr stay stable until mem_ack is sampled 1.
- mem_ack sampled 1 in MEM_WAIT:
  - mem_req drops next cycle; reg_write pulses next cycle with write_reg = latched destination; state→IDLE.
  - in_ready is 1 in that same cycle, so a new accept may coincide with the write pulse.
- Load data extraction:
  - LW: write_data=mem_rdata. Misaligned address bits are ignored and no exception is raised.
  - LB: byte selected little-endian by latched addr[1:0] (00→[7:0], 01→[15:8], 10→[23:16], 11→[31:24]), sign-extended to 32 bits.
- Timeout:
  - The counter increments each MEM_WAIT cycle without ack.
  - When it reaches TIMEOUT_CYCLES (nonzero): mem_req→0, err pulses one cycle, no register write, state→IDLE, counter cleared.
  - If ack and timeout occur in the same cycle, ack wins.
- mem_ack is ignored outside MEM_WAIT, including in the accept cycle.
- A load to register 0 performs the memory read but writes nothing.

Test Plan:
- ADDIU accept, in_alu_result=0x0000_0005, in_write_reg=8 → next cycle reg_write=1, write_reg=8, write_data=5; following cycle reg_write=0.
- LB with address 0x1003, mem_ack 3 cycles after mem_req, mem_rdata=0x80FF_0000 → mem_addr=0x1000, then reg_write pulse with write_data=0xFFFF_FF80. A second LB at 0x1002 → 0xFFFF_FFFF.
- Three back-to-back ORI, then SW, then JAL (npc=0x0000_0040, reg 31) → three consecutive write pulses, a gap cycle, then write_reg=31, write_data=0x40.
- TIMEOUT_CYCLES=4, LW issued, mem_ack never asserted → err pulses after 4 wait cycles, mem_req=0, no reg_write, in_ready=1.
- rst_n asserted low mid-MEM_WAIT → all outputs 0 immediately without a clock edge. A late mem_ack after release produces no reg_write.
- R-type JR (func 001000) and ADDI to reg 0 → accepted, reg_write stays 0.
